// File: rtl/float_to_fixed_serial.sv
// float_to_fixed_serial
// Converts an IEEE-754 single-precision operand into a 32-bit two's-complement
// fixed-point word. The caller chooses the number of fraction bits at runtime.
// The significand is aligned one bit per clock, so the block stays small.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid     float_in / fixpointpos are valid
//   in_ready     block can accept an operand (IDLE only)
//   float_in     IEEE-754 single {s, e[7:0], m[22:0]}
//   fixpointpos  number of fraction bits in the result (0..31)
//   out_valid    fixed_out / overflow are valid
//   out_ready    consumer accepts the result
//   fixed_out    two's-complement fixed-point result
//   overflow     result saturated, or the input was Inf/NaN
module float_to_fixed_serial #(
    parameter int MAX_RSHIFT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float_in,
    input  logic [4:0]  fixpointpos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fixed_out,
    output logic        overflow
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SIGN  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic signed [9:0] LP_MAXR_S = 10'(MAX_RSHIFT);
    localparam logic [4:0]        LP_MAXR_N = 5'(MAX_RSHIFT);

    logic [2:0]  r_state;
    logic [31:0] r_float;
    logic [4:0]  r_fpp;
    logic [31:0] r_mag;
    logic [4:0]  r_n;
    logic        r_left;
    logic        r_sat;
    logic        r_exactMin;
    logic        r_sign;

    logic              w_s;
    logic [7:0]        w_exp;
    logic [22:0]       w_man;
    logic [23:0]       w_sig;
    logic signed [9:0] w_k;
    logic signed [9:0] w_negK;
    logic [4:0]        w_rshift;
    logic [31:0]       w_negMag;

    assign w_s   = r_float[31];
    assign w_exp = r_float[30:23];
    assign w_man = r_float[22:0];
    assign w_sig = {1'b1, w_man};

    // k = e - 150 + fixpointpos; 10 signed bits cover -150..136 so a large
    // fixpointpos with a large exponent can never wrap into a small shift.
    assign w_k    = $signed({2'b00, w_exp}) - 10'sd150 + $signed({5'b00000, r_fpp});
    assign w_negK = -w_k;

    // Right shifts of MAX_RSHIFT or more already produce zero, so cap the count.
    assign w_rshift = (w_negK >= LP_MAXR_S) ? LP_MAXR_N : w_negK[4:0];

    assign w_negMag = ~r_mag + 32'd1;

    assign in_ready = (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_float    <= '0;
            r_fpp      <= '0;
            r_mag      <= '0;
            r_n        <= '0;
            r_left     <= 1'b0;
            r_sat      <= 1'b0;
            r_exactMin <= 1'b0;
            r_sign     <= 1'b0;
            fixed_out  <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_float <= float_in;
                        r_fpp   <= fixpointpos;
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    r_sat      <= 1'b0;
                    r_exactMin <= 1'b0;
                    r_sign     <= w_s;
                    r_mag      <= {8'h00, w_sig};
                    r_n        <= '0;
                    r_left     <= 1'b0;
                    r_state    <= S_SIGN;
                    if (w_exp == 8'd0) begin
                        // Zero and denormals flush to zero.
                        r_mag <= '0;
                    end else if (w_exp == 8'hFF) begin
                        // NaN always saturates positive; Inf keeps its sign.
                        r_sat  <= 1'b1;
                        r_sign <= (w_man != '0) ? 1'b0 : w_s;
                    end else if (w_k >= 10'sd8) begin
                        // -2^31 is the one magnitude of 2^31 that is representable.
                        if (w_k == 10'sd8 && w_man == '0 && w_s)
                            r_exactMin <= 1'b1;
                        else
                            r_sat <= 1'b1;
                    end else if (w_k > 10'sd0) begin
                        r_n     <= w_k[4:0];
                        r_left  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else if (w_k < 10'sd0) begin
                        r_n     <= w_rshift;
                        r_left  <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_mag <= r_left ? {r_mag[30:0], 1'b0} : {1'b0, r_mag[31:1]};
                    r_n   <= r_n - 5'd1;
                    if (r_n == 5'd1)
                        r_state <= S_SIGN;
                end

                S_SIGN: begin
                    if (r_sat) begin
                        fixed_out <= r_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        overflow  <= 1'b1;
                    end else if (r_exactMin) begin
                        fixed_out <= 32'h8000_0000;
                        overflow  <= 1'b0;
                    end else begin
                        fixed_out <= r_sign ? w_negMag : r_mag;
                        overflow  <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fixed_serial.sv
// tb_float_to_fixed_serial
// Self-checking bench for float_to_fixed_serial: a table of directed float
// operands with hand-computed results and latencies, followed by handshake
// hold and asynchronous-reset sequences.
module tb_float_to_fixed_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_in;
    logic [4:0]  fixpointpos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fixed_out;
    logic        overflow;

    int compared;
    int mismatched;

    typedef struct {
        string       name;
        logic [31:0] fl;
        logic [4:0]  fpp;
        logic [31:0] expFixed;
        logic        expOvf;
        int          expLat;
    } vec_t;

    vec_t vecs[16];

    float_to_fixed_serial #(.MAX_RSHIFT(24)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .float_in(float_in),
        .fixpointpos(fixpointpos),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fixed_out(fixed_out),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Accept one operand (edge 1) and wait, bounded, for out_valid.
    task automatic applyStimulus(input logic [31:0] f, input logic [4:0] p, output int lat);
        @(negedge clk);
        in_valid    = 1'b1;
        float_in    = f;
        fixpointpos = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("inReadyBusy", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid && lat < 40 && in_ready)
                checkOutput("inReadyHeld", {31'd0, in_ready}, 32'd0);
        end
    endtask

    // Hand the result to the consumer and confirm the return to IDLE.
    task automatic releaseResult;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("outValidDrop", {31'd0, out_valid}, 32'd0);
        checkOutput("inReadyBack", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        float_in    = '0;
        fixpointpos = '0;
        out_ready   = 1'b0;

        vecs[0]  = '{"one_fpp16",     32'h3F80_0000, 5'd16, 32'h0001_0000, 1'b0, 10};
        vecs[1]  = '{"neg2p5_fpp8",   32'hC020_0000, 5'd8,  32'hFFFF_FD80, 1'b0, 17};
        vecs[2]  = '{"pos2e31",       32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 3};
        vecs[3]  = '{"neg2e31exact",  32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b0, 3};
        vecs[4]  = '{"one_fpp31",     32'h3F80_0000, 5'd31, 32'h7FFF_FFFF, 1'b1, 3};
        vecs[5]  = '{"zero",          32'h0000_0000, 5'd5,  32'h0000_0000, 1'b0, 3};
        vecs[6]  = '{"denormal",      32'h0000_0001, 5'd31, 32'h0000_0000, 1'b0, 3};
        vecs[7]  = '{"nan",           32'h7FC0_0000, 5'd4,  32'h7FFF_FFFF, 1'b1, 3};
        vecs[8]  = '{"negInf",        32'hFF80_0000, 5'd4,  32'h8000_0000, 1'b1, 3};
        vecs[9]  = '{"quarter_cap24", 32'h3E80_0000, 5'd1,  32'h0000_0000, 1'b0, 27};
        vecs[10] = '{"tiny_cap",      32'h3380_0000, 5'd0,  32'h0000_0000, 1'b0, 27};
        vecs[11] = '{"eighth_k-25",   32'h3E00_0000, 5'd1,  32'h0000_0000, 1'b0, 27};
        vecs[12] = '{"left3",         32'h4B00_0000, 5'd3,  32'h0400_0000, 1'b0, 6};
        vecs[13] = '{"left7",         32'h4B00_0001, 5'd7,  32'h4000_0080, 1'b0, 10};
        vecs[14] = '{"negLeft4",      32'hCB40_0000, 5'd4,  32'hF400_0000, 1'b0, 7};
        vecs[15] = '{"kZero",         32'h4B00_0005, 5'd0,  32'h0080_0005, 1'b0, 3};

        // Reset state while rst is held low.
        #12;
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstFixed", fixed_out, 32'd0);
        checkOutput("rstOverflow", {31'd0, overflow}, 32'd0);
        rst = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].fl, vecs[i].fpp, lat);
            checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].expLat));
            checkOutput({vecs[i].name, "_fixed"}, fixed_out, vecs[i].expFixed);
            checkOutput({vecs[i].name, "_ovf"}, {31'd0, overflow}, {31'd0, vecs[i].expOvf});
            releaseResult();
        end

        // Truncation toward zero on a negative value: -2.5 with 0 fraction bits.
        applyStimulus(32'hC020_0000, 5'd0, lat);
        checkOutput("truncNeg_lat", 32'(lat), 32'd25);
        checkOutput("truncNeg_fixed", fixed_out, 32'hFFFF_FFFE);
        releaseResult();

        // Hold out_ready low: outputs stay put and busy in_valid pulses are ignored.
        applyStimulus(32'hC020_0000, 5'd8, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            float_in    = 32'h3F80_0000;
            fixpointpos = 5'd16;
            @(posedge clk);
            #1;
            checkOutput("holdValid", {31'd0, out_valid}, 32'd1);
            checkOutput("holdFixed", fixed_out, 32'hFFFF_FD80);
            checkOutput("holdOvf", {31'd0, overflow}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        releaseResult();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("noStrayAccept", {31'd0, out_valid}, 32'd0);
        checkOutput("noStrayIdle", {31'd0, in_ready}, 32'd1);

        // Leave a saturated result in the output registers, then reset mid-SHIFT.
        applyStimulus(32'h7FC0_0000, 5'd0, lat);
        releaseResult();
        @(negedge clk);
        in_valid    = 1'b1;
        float_in    = 32'h3380_0000;
        fixpointpos = 5'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRstValid", {31'd0, out_valid}, 32'd0);
        checkOutput("midRstFixed", fixed_out, 32'd0);
        checkOutput("midRstOvf", {31'd0, overflow}, 32'd0);
        checkOutput("midRstReady", {31'd0, in_ready}, 32'd1);
        #1;
        rst = 1'b1;

        // Normal operation resumes after the reset.
        applyStimulus(32'h3F80_0000, 5'd16, lat);
        checkOutput("postRst_lat", 32'(lat), 32'd10);
        checkOutput("postRst_fixed", fixed_out, 32'h0001_0000);
        releaseResult();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/float_to_fixed_serial.md
Name: float_to_fixed_serial

Overview:
- Converts an IEEE-754 single-precision operand to a 32-bit two's-complement fixed-point word with a runtime-selectable binary-point position.
- Sits on the return path of the numeric datapath, consuming float words and delivering fixed-point words back to integer logic.
- Alignment is bit-serial, one shift per clock, to keep area small.
- Input and output each use a valid/ready handshake.

Parameters:
- MAX_RSHIFT, 24, right-shift count cap; any shift of 24 or more yields 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  float_in and fixpointpos are valid.
- in_ready  out  1  block can accept an operand.
- float_in  in  32  IEEE-754 single: s = [31], e = [30:23], m = [22:0].
- fixpointpos  in  5  number of fraction bits in the result (0..31).
- out_valid  out  1  fixed_out and overflow are valid.
- out_ready  in  1  consumer accepts the result.
- fixed_out  out  32  two's-complement fixed-point result.
- overflow  out  1  result saturated, or input was Inf/NaN.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low; while rst = 0, all state clears immediately.
- Reset values: state = IDLE, fixed_out = 0, out_valid = 0, overflow = 0, in_ready = 1.
- in_ready: combinational, 1 only in IDLE.
- Accept: occurs at a rising edge with in_valid = 1 and in_ready = 1. float_in and fixpointpos are captured; IDLE -> CHECK. In any other state, in_valid is ignored.
- CHECK: compute sig = {1, m} (24 bits) and k = e - 150 + fixpointpos (signed, 10 bits). Classification, in priority order:
  - e = 0 (zero or denormal): mag = 0, no overflow; -> SIGN.
  - e = 255: sat = 1, overflow = 1. NaN (m != 0) forces a positive result; Inf keeps s. -> SIGN.
  - k >= 8: overflow, except k = 8, m = 0, s = 1, which is the exact -2^31 (flag set, no overflow). -> SIGN.
  - 0 < k <= 7: n = k, left shift; -> SHIFT.
  - k < 0: n = min(-k, 24), right shift; -> SHIFT.
  - k = 0: n = 0; -> SIGN.
- SHIFT: each edge shifts the 32-bit magnitude register one bit (left or right, zero fill; right shift truncates toward zero) and decrements n. The edge on which n goes 1 -> 0 also moves to SIGN.
- SIGN: one edge, then -> DONE with out_valid = 1.
  - sat with positive sign: fixed_out = 0x7FFFFFFF.
  - sat with negative sign: fixed_out = 0x80000000.
  - exact -2^31 case: fixed_out = 0x80000000, overflow = 0.
  - otherwise: fixed_out = s ? -mag : mag (32-bit two's complement).
- DONE: fixed_out and overflow hold stable while out_ready = 0. At the edge where out_ready = 1, out_valid -> 0 and state -> IDLE. No same-cycle re-accept; the next accept is possible one edge later.
- Latency: counting the accepting edge as edge 1, out_valid rises on edge n + 3. n = 0 for all special cases; worst case n = 24 gives 27 edges.
- Reset mid-operation (any state): all outputs return to their reset values immediately; the operation in flight is discarded.
- Out-of-range exponent: fixpointpos = 31 with e near 127 must not wrap; k is computed with full signed width.

Test Plan:
1. 0x3F800000 (1.0), fpp = 16 -> n = 7; fixed_out = 0x00010000, overflow = 0; out_valid on edge 10; in_ready = 0 from edge 1 until return to IDLE.
2. 0xC0200000 (-2.5), fpp = 8 -> n = 14; fixed_out = 0xFFFFFD80 (-640), overflow = 0.
3. 0x4F000000 (2^31), fpp = 0 -> 0x7FFFFFFF, overflow = 1. 0xCF000000 -> 0x80000000, overflow = 0. 0x3F800000 with fpp = 31 -> 0x7FFFFFFF, overflow = 1.
4. Special inputs, each with latency 3:
   - 0x00000000 and 0x00000001 -> 0x00000000, overflow = 0.
   - 0x7FC00000 (NaN) -> 0x7FFFFFFF, overflow = 1.
   - 0xFF800000 (-Inf) -> 0x80000000, overflow = 1.
5. 0x3E800000 (0.25), fpp = 1 -> n = 24 (cap boundary); fixed_out = 0. 0x33800000 with fpp = 0 -> n capped at 24; fixed_out = 0, out_valid on edge 27.
6. Handshake and reset:
   - Hold out_ready = 0 for 5 cycles after out_valid -> outputs stable; in_valid pulses during busy are not accepted.
   - Pulse rst low mid-SHIFT -> out_valid = 0, fixed_out = 0, in_ready = 1 immediately, without waiting for a clock edge.
